zbt_port_ctrl: RTL and testbench

Single-port ZBT SRAM access controller in the fpga_clock domain, downstream of the deskewed clock generator. Holds the RAM interface idle until the clock generator reports lock, then lets it settle. Afterwards it accepts one read or write request per cycle through a valid/ready handshake. It drives the ZBT pins with correct two-cycle pipelined data timing and returns read data with fixed latency.

---
 rtl/zbt_port_ctrl.sv | 158 +++++++++++++++
 tb/tb_zbt_port_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_port_ctrl.sv
// Single-port ZBT SRAM access controller: lock/settle gating, one request per
// cycle, pipelined write data two cycles behind address, fixed 4-cycle read latency.
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_LOCK | clock generator not locked; RAM deselected, clock disabled
// SETTLE    | locked, counting settle cycles before opening the port
// RUN       | accepting requests; RAM clock and output enables active
module zbt_port_ctrl #(
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 36,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              locked,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_address,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_we_b,
  output logic              ram_ce_b,
  output logic              ram_cen_b,
  output logic              ram_adv_ld,
  output logic              ram_oe_b,
  output logic [3:0]        ram_bwe_b
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  // The WAIT_LOCK cycle that sees lock counts as the first settle cycle.
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    CNT_W'((SETTLE_CYCLES >= 2) ? (SETTLE_CYCLES - 2) : 0);

  state_t             state;
  logic [CNT_W-1:0]   settle_cnt;

  logic               accept;
  logic               flush;

  logic               wr_v1, wr_v2;
  logic               rd_v1, rd_v2, rd_v3;
  logic [DATA_W-1:0]  wdata1, wdata2;
  logic [DATA_W-1:0]  dout;
  logic               dout_en;

  assign req_ready  = (state == RUN) && locked;
  assign accept     = req_valid && req_ready;
  assign flush      = !locked;

  assign ram_adv_ld = 1'b0;
  assign ram_bwe_b  = 4'b0000;
  assign ram_data   = dout_en ? dout : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      ram_cen_b  <= 1'b1;
      ram_oe_b   <= 1'b1;
    end else begin
      ram_cen_b <= 1'b1;
      ram_oe_b  <= 1'b1;
      case (state)
        WAIT_LOCK: begin
          if (locked) begin
            if (SETTLE_CYCLES <= 1) begin
              state     <= RUN;
              ram_cen_b <= 1'b0;
              ram_oe_b  <= 1'b0;
            end else begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end
          end
        end
        SETTLE: begin
          if (!locked) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
          end else if (settle_cnt == '0) begin
            state     <= RUN;
            ram_cen_b <= 1'b0;
            ram_oe_b  <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        RUN: begin
          if (!locked) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
          end else begin
            ram_cen_b <= 1'b0;
            ram_oe_b  <= 1'b0;
          end
        end
        default: begin
          state      <= WAIT_LOCK;
          settle_cnt <= '0;
        end
      endcase
    end
  end

  // Lock loss kills every in-flight slot on the same edge it is seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_address <= '0;
      ram_we_b    <= 1'b1;
      ram_ce_b    <= 1'b1;
      wr_v1       <= 1'b0;
      wr_v2       <= 1'b0;
      rd_v1       <= 1'b0;
      rd_v2       <= 1'b0;
      rd_v3       <= 1'b0;
      wdata1      <= '0;
      wdata2      <= '0;
      dout        <= '0;
      dout_en     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      ram_ce_b <= !accept;
      ram_we_b <= !(accept && req_we);
      if (accept) begin
        ram_address <= req_addr;
      end

      wdata1  <= req_wdata;
      wdata2  <= wdata1;
      dout    <= wdata2;

      wr_v1   <= accept && req_we;
      wr_v2   <= wr_v1 && !flush;
      dout_en <= wr_v2 && !flush;

      rd_v1    <= accept && !req_we;
      rd_v2    <= rd_v1 && !flush;
      rd_v3    <= rd_v2 && !flush;
      rd_valid <= rd_v3 && !flush;
      if (rd_v3 && !flush) begin
        rd_data <= ram_data;
      end
    end
  end

endmodule

// File: tb/tb_zbt_port_ctrl.sv
// Bench for zbt_port_ctrl: cycle table for write/read/stream/interleave traffic
// against a pipelined ZBT SRAM model, plus directed lock-loss and reset sequences.
module tb_zbt_port_ctrl;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 36;
  localparam int SETTLE = 16;
  localparam int NVEC   = 30;
  localparam int NCYC   = NVEC + 6;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              locked = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ram_address;
  wire  [DATA_W-1:0] ram_data;
  logic              ram_we_b, ram_ce_b, ram_cen_b, ram_adv_ld, ram_oe_b;
  logic [3:0]        ram_bwe_b;

  always #5 clk = ~clk;

  zbt_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n), .locked(locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_we_b(ram_we_b), .ram_ce_b(ram_ce_b), .ram_cen_b(ram_cen_b),
    .ram_adv_ld(ram_adv_ld), .ram_oe_b(ram_oe_b), .ram_bwe_b(ram_bwe_b)
  );

  // Pipelined ZBT model: address at edge A, read data driven A+1..A+2, write data taken at A+2.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              s1_v = 1'b0, s1_we = 1'b0, s2_v = 1'b0, s2_we = 1'b0, sram_drv = 1'b0;
  logic [ADDR_W-1:0] s1_a = '0, s2_a = '0;
  logic [DATA_W-1:0] sram_q = '0;
  wire               sram_oe = sram_drv & ~ram_oe_b;
  assign ram_data = sram_oe ? sram_q : {DATA_W{1'bz}};

  always @(posedge clk) begin
    if (ram_cen_b) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      sram_drv <= 1'b0;
    end else begin
      s1_v     <= ~ram_ce_b;
      s1_we    <= ~ram_we_b;
      s1_a     <= ram_address;
      s2_v     <= s1_v;
      s2_we    <= s1_we;
      s2_a     <= s1_a;
      sram_drv <= s1_v & ~s1_we;
      if (s2_v && s2_we) mem[s2_a] <= ram_data;
      if (s2_v && s2_we && s2_a == s1_a) sram_q <= ram_data;
      else                               sram_q <= mem[s1_a];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rd_valid"},  64'(rd_valid),  64'd0);
    chk({tag, "_rd_data"},   64'(rd_data),   64'd0);
    chk({tag, "_address"},   64'(ram_address), 64'd0);
    chk({tag, "_we_b"},      64'(ram_we_b),  64'd1);
    chk({tag, "_ce_b"},      64'(ram_ce_b),  64'd1);
    chk({tag, "_cen_b"},     64'(ram_cen_b), 64'd1);
    chk({tag, "_oe_b"},      64'(ram_oe_b),  64'd1);
    chk({tag, "_bus"},       64'(ram_data),  64'd0);
  endtask

  // Entered just after locked has been driven high; counts cycles until req_ready.
  task automatic measure_settle(input string nm, input int quiet_n);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      chk("settle_rd_valid", 64'(rd_valid), 64'd0);
      chk("settle_cen_b", 64'(ram_cen_b), 64'd1);
      if (n < quiet_n) begin
        chk("abort_bus_idle", 64'(ram_data), 64'd0);
        chk("abort_ce_b", 64'(ram_ce_b), 64'd1);
        chk("abort_we_b", 64'(ram_we_b), 64'd1);
      end
      next_cycle();
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(n), 64'(SETTLE));
  endtask

  task automatic single_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] x,
                             input string nm);
    next_cycle();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    @(negedge clk);
    chk({nm, "_ready"}, 64'(req_ready), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_rd_valid"}, 64'(rd_valid), 64'(i == 4));
    end
    chk({nm, "_rd_data"}, 64'(rd_data), 64'(x));
  endtask

  typedef struct {
    logic              v;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] x;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] x);
    vec_t r;
    r.v = v; r.we = we; r.a = a; r.d = d; r.x = x;
    return r;
  endfunction

  vec_t              vec [NVEC];
  logic              acc_v [NCYC];
  logic              acc_we [NCYC];
  logic [ADDR_W-1:0] acc_a [NCYC];
  logic [DATA_W-1:0] acc_d [NCYC];
  logic [DATA_W-1:0] acc_x [NCYC];
  logic [DATA_W-1:0] last_rd;
  logic              pv1, pw1, wslot, rslot;

  initial begin
    vec[0] = mk(1'b1, 1'b1, 19'h00010, 36'h9ABCD1234, 36'h0);
    vec[1] = mk(1'b0, 1'b0, 19'h0, 36'h0, 36'h0);
    vec[2] = mk(1'b1, 1'b0, 19'h00010, 36'h0, 36'h9ABCD1234);
    vec[3] = mk(1'b0, 1'b0, 19'h0, 36'h0, 36'h0);
    vec[4] = mk(1'b0, 1'b0, 19'h0, 36'h0, 36'h0);
    vec[5] = mk(1'b0, 1'b0, 19'h0, 36'h0, 36'h0);
    for (int i = 0; i < 8; i++) begin
      vec[6 + i]  = mk(1'b1, 1'b1, ADDR_W'(i), DATA_W'(i * 3), 36'h0);
      vec[14 + i] = mk(1'b1, 1'b0, ADDR_W'(i), 36'h0, DATA_W'(i * 3));
    end
    for (int j = 0; j < 3; j++) begin
      vec[22 + 2*j] = mk(1'b1, 1'b1, 19'h7FFFF, 36'hFFFFFFFFF, 36'h0);
      vec[23 + 2*j] = mk(1'b1, 1'b0, 19'h7FFFF, 36'h0, 36'hFFFFFFFFF);
    end
    vec[28] = mk(1'b1, 1'b1, 19'h7FFFF, 36'h012345678, 36'h0);
    vec[29] = mk(1'b1, 1'b0, 19'h7FFFF, 36'h0, 36'h012345678);

    // Reset values
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");

    // Startup gating
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      next_cycle();
      @(negedge clk);
      chk("nolock_ready", 64'(req_ready), 64'd0);
      chk("nolock_cen_b", 64'(ram_cen_b), 64'd1);
    end
    next_cycle();
    locked = 1'b1;
    measure_settle("startup_settle_cycles", 0);

    // Table-driven traffic with cycle-exact pin and read-return checks
    last_rd = '0;
    for (int c = 0; c < NCYC; c++) begin
      next_cycle();
      if (c < NVEC) begin
        req_valid = vec[c].v;
        req_we    = vec[c].we;
        req_addr  = vec[c].a;
        req_wdata = vec[c].d;
        acc_v[c] = vec[c].v; acc_we[c] = vec[c].we; acc_a[c] = vec[c].a;
        acc_d[c] = vec[c].d; acc_x[c] = vec[c].x;
      end else begin
        req_valid = 1'b0;
        acc_v[c] = 1'b0; acc_we[c] = 1'b0; acc_a[c] = '0; acc_d[c] = '0; acc_x[c] = '0;
      end
      @(negedge clk);
      pv1 = 1'b0; pw1 = 1'b0; wslot = 1'b0; rslot = 1'b0;
      if (c >= 1) begin pv1 = acc_v[c-1]; pw1 = acc_we[c-1]; end
      if (c >= 3) wslot = acc_v[c-3] && acc_we[c-3];
      if (c >= 4) rslot = acc_v[c-4] && !acc_we[c-4];
      chk("tbl_ready", 64'(req_ready), 64'd1);
      chk("tbl_ce_b", 64'(ram_ce_b), 64'(!pv1));
      chk("tbl_we_b", 64'(ram_we_b), 64'(!(pv1 && pw1)));
      if (pv1) chk("tbl_address", 64'(ram_address), 64'(acc_a[c-1]));
      chk("tbl_run_pins", 64'({ram_cen_b, ram_oe_b, ram_adv_ld, ram_bwe_b}), 64'd0);
      chk("tbl_bus_contention", 64'(sram_oe && wslot), 64'd0);
      if (wslot)         chk("tbl_wr_bus", 64'(ram_data), 64'(acc_d[c-3]));
      else if (!sram_oe) chk("tbl_idle_bus", 64'(ram_data), 64'd0);
      chk("tbl_rd_valid", 64'(rd_valid), 64'(rslot));
      if (rslot) begin
        chk("tbl_rd_data", 64'(rd_data), 64'(acc_x[c-4]));
        last_rd = acc_x[c-4];
      end else begin
        chk("tbl_rd_hold", 64'(rd_data), 64'(last_rd));
      end
    end

    // Lock loss with two reads and one write in flight
    next_cycle(); req_valid = 1'b1; req_we = 1'b0; req_addr = 19'h00010;
    next_cycle(); req_valid = 1'b1; req_we = 1'b0; req_addr = 19'h00003;
    next_cycle(); req_valid = 1'b1; req_we = 1'b1; req_addr = 19'h00020; req_wdata = 36'h5A5A5A5A5;
    next_cycle(); req_valid = 1'b0; locked = 1'b0;
    #1;
    chk("lockdrop_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("lockdrop_rd_valid", 64'(rd_valid), 64'd0);
    next_cycle(); locked = 1'b1;
    measure_settle("relock_settle_cycles", 5);
    single_read(19'h00010, 36'h9ABCD1234, "relock_read");

    // Async reset in the middle of streaming reads
    for (int p = 0; p < 6; p++) begin
      next_cycle();
      req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_W'(p);
      if (p >= 4) begin
        #1;
        chk("stream_rd_valid", 64'(rd_valid), 64'd1);
        chk("stream_rd_data", 64'(rd_data), 64'((p - 4) * 3));
      end
    end
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      next_cycle();
      @(negedge clk);
      chk("postreset_no_rd_valid", 64'(rd_valid), 64'd0);
    end
    chk("postreset_run", 64'(req_ready), 64'd1);
    single_read(19'h00005, 36'h00000000F, "postreset_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
